// File: rtl/timer_pkg.sv
// Shared types, constants and BCD helpers for the countdown timer controller.
package timer_pkg;

   localparam int DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] digit_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam digit_t BCD_MAX  = 4'd9;
   localparam digit_t TENS_MAX = 4'd5;

   typedef struct packed {
      digit_t min;
      digit_t tens;
      digit_t ones;
   } time_t;

   function automatic logic digit_ok(input digit_t d);
      return d <= BCD_MAX;
   endfunction

   function automatic logic time_is_zero(input time_t t);
      return (t.min == '0) && (t.tens == '0) && (t.ones == '0);
   endfunction

   function automatic logic time_is_last(input time_t t);
      return (t.min == '0) && (t.tens == '0) && (t.ones == 4'd1);
   endfunction

   // A time is runnable only when nonzero and the tens digit is a real
   // tens-of-seconds value; keyed entries such as 0:99 are rejected.
   function automatic logic time_startable(input time_t t);
      return !time_is_zero(t) && (t.tens <= TENS_MAX);
   endfunction

   // One-second BCD decrement with borrow ones -> tens -> minutes.
   // Callers never decrement 0:00, so the minutes borrow cannot underflow.
   function automatic time_t bcd_dec(input time_t t);
      time_t r;
      r = t;
      if (t.ones != '0) begin
         r.ones = t.ones - 4'd1;
      end else begin
         r.ones = BCD_MAX;
         if (t.tens != '0) begin
            r.tens = t.tens - 4'd1;
         end else begin
            r.tens = TENS_MAX;
            r.min  = t.min - 4'd1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every CLKS_PER_SEC cycles.
// Used by countdown_timer_ctrl only when TIMER_PRESCALE_EN is defined.
module tick_prescaler
   import timer_pkg::*;
#(
   parameter int unsigned CLKS_PER_SEC = 100000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic hold,
   output logic tick
);

   localparam int unsigned CNT_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_SEC - 1);

   logic [CNT_W-1:0] cnt_q;

   assign tick = !clear && !hold && (cnt_q == TERM);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt_q <= '0;
      end else if (!hold) begin
         if (cnt_q == TERM) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Keypad-entry BCD countdown timer: IDLE/RUN/PAUSE/DONE FSM driving three digits.
// Define TIMER_PRESCALE_EN to derive the 1 Hz tick internally from CLKS_PER_SEC.
module countdown_timer_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned CLKS_PER_SEC = 100000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sec_tick,
   input  logic [DIGIT_W-1:0] key_digit,
   input  logic               key_valid,
   input  logic               start,
   input  logic               stop_clear,
   output logic [DIGIT_W-1:0] min,
   output logic [DIGIT_W-1:0] sec_tens,
   output logic [DIGIT_W-1:0] sec_ones,
   output logic               running,
   output logic               done
);

   state_e state_q;
   time_t  time_q;
   logic   running_q;
   logic   done_q;
   logic   tick;

`ifdef TIMER_PRESCALE_EN
   tick_prescaler #(
      .CLKS_PER_SEC (CLKS_PER_SEC)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clear ((state_q == IDLE) || (state_q == DONE)),
      .hold  (state_q == PAUSE),
      .tick  (tick)
   );
`else
   // A zero CLKS_PER_SEC describes a design with no time base at all.
   assign tick = sec_tick && (CLKS_PER_SEC != 0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         time_q    <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (stop_clear) begin
                  time_q <= '0;
               end else if (start) begin
                  if (time_startable(time_q)) begin
                     state_q   <= RUN;
                     running_q <= 1'b1;
                  end
               end else if (key_valid && digit_ok(key_digit)) begin
                  time_q <= {time_q.tens, time_q.ones, key_digit};
               end
            end

            RUN: begin
               if (stop_clear) begin
                  state_q   <= PAUSE;
                  running_q <= 1'b0;
               end else if (tick) begin
                  time_q <= bcd_dec(time_q);
                  if (time_is_last(time_q)) begin
                     state_q   <= DONE;
                     running_q <= 1'b0;
                     done_q    <= 1'b1;
                  end
               end
            end

            PAUSE: begin
               if (stop_clear) begin
                  state_q <= IDLE;
                  time_q  <= '0;
               end else if (start) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end
            end

            DONE: begin
               // Any request only acknowledges completion; it is not replayed in IDLE.
               if (start || stop_clear || key_valid) begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign min      = time_q.min;
   assign sec_tens = time_q.tens;
   assign sec_ones = time_q.ones;
   assign running  = running_q;
   assign done     = done_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Self-checking bench for countdown_timer_ctrl: directed scenarios plus
// randomized traffic compared against a seconds-based reference model.
module tb_countdown_timer_ctrl;

   localparam int CPS = 4;
   localparam int MI = 0, MR = 1, MP = 2, MD = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sec_tick = 1'b0;
   logic [3:0] key_digit = '0;
   logic       key_valid = 1'b0;
   logic       start = 1'b0;
   logic       stop_clear = 1'b0;
   logic [3:0] min, sec_tens, sec_ones;
   logic       running, done;

   int n_tests = 0;
   int n_fail  = 0;

   int m_st = MI;
   int m_d[3] = '{0, 0, 0};
   int m_pc = 0;

   countdown_timer_ctrl #(.CLKS_PER_SEC(CPS)) dut (
      .clk        (clk),
      .reset      (reset),
      .sec_tick   (sec_tick),
      .key_digit  (key_digit),
      .key_valid  (key_valid),
      .start      (start),
      .stop_clear (stop_clear),
      .min        (min),
      .sec_tens   (sec_tens),
      .sec_ones   (sec_ones),
      .running    (running),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] model_digits();
      logic [11:0] v;
      v = {m_d[0][3:0], m_d[1][3:0], m_d[2][3:0]};
      return v;
   endfunction

   // Reference model: time handled as a seconds total, not as a BCD borrow chain.
   task automatic model_step();
      int  old_st;
      int  secs;
      bit  tk;
      old_st = m_st;
`ifdef TIMER_PRESCALE_EN
      tk = (m_st == MR) && (m_pc == CPS - 1);
`else
      tk = sec_tick;
`endif
      if (reset) begin
         m_st = MI;
         m_d  = '{0, 0, 0};
         m_pc = 0;
         return;
      end
      case (m_st)
         MI: begin
            if (stop_clear) m_d = '{0, 0, 0};
            else if (start) begin
               if ((m_d[0] + m_d[1] + m_d[2]) != 0 && m_d[1] <= 5) m_st = MR;
            end else if (key_valid && key_digit <= 9) begin
               m_d = '{m_d[1], m_d[2], int'(key_digit)};
            end
         end
         MR: begin
            if (stop_clear) m_st = MP;
            else if (tk) begin
               secs = m_d[0] * 60 + m_d[1] * 10 + m_d[2] - 1;
               m_d  = '{secs / 60, (secs % 60) / 10, secs % 10};
               if (secs == 0) m_st = MD;
            end
         end
         MP: begin
            if (stop_clear) begin
               m_st = MI;
               m_d  = '{0, 0, 0};
            end else if (start) m_st = MR;
         end
         default: begin
            if (start || stop_clear || key_valid) m_st = MI;
         end
      endcase
      if (old_st == MR) m_pc = (m_pc + 1) % CPS;
      else if (old_st != MP) m_pc = 0;
   endtask

   // One clock: DUT and model consume the same inputs, then outputs are compared.
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check("digits",  {min, sec_tens, sec_ones}, model_digits());
      check("running", running, m_st == MR);
      check("done",    done,    m_st == MD);
      reset      = 1'b0;
      key_valid  = 1'b0;
      start      = 1'b0;
      stop_clear = 1'b0;
      sec_tick   = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [11:0] dig, input logic run, input logic dn);
      check({tag, "_digits"},  {min, sec_tens, sec_ones}, dig);
      check({tag, "_running"}, running, run);
      check({tag, "_done"},    done, dn);
   endtask

   task automatic key(input logic [3:0] d);
      key_digit = d;
      key_valid = 1'b1;
      step();
   endtask

   task automatic press_start();
      start = 1'b1;
      step();
   endtask

   task automatic press_clear();
      stop_clear = 1'b1;
      step();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         sec_tick = 1'b1;
         step();
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #1;
      reset = 1'b1;
      step();
      expect_out("reset", 12'h000, 1'b0, 1'b0);

`ifndef TIMER_PRESCALE_EN
      key(4'd1); key(4'd3); key(4'd0);
      press_start();
      expect_out("load130", 12'h130, 1'b1, 1'b0);
      ticks(89);
      expect_out("at001", 12'h001, 1'b1, 1'b0);
      ticks(1);
      expect_out("done", 12'h000, 1'b0, 1'b1);

      key(4'd7);
      expect_out("done_exit", 12'h000, 1'b0, 1'b0);
      key(4'd7);
      expect_out("after_exit", 12'h007, 1'b0, 1'b0);
      press_clear();

      key(4'd2); key(4'd0); key(4'd0);
      press_start();
      ticks(1);
      expect_out("borrow_min", 12'h159, 1'b1, 1'b0);
      press_clear(); press_clear();
      key(4'd1); key(4'd0);
      press_start();
      ticks(1);
      expect_out("borrow_tens", 12'h009, 1'b1, 1'b0);
      press_clear(); press_clear();

      key(4'd9); key(4'd9);
      press_start();
      expect_out("start_099", 12'h099, 1'b0, 1'b0);
      key(4'd10);
      expect_out("key10", 12'h099, 1'b0, 1'b0);
      press_clear();
      press_start();
      expect_out("start_000", 12'h000, 1'b0, 1'b0);

      key(4'd4); key(4'd5);
      press_start();
      stop_clear = 1'b1;
      sec_tick   = 1'b1;
      step();
      expect_out("pause_tick", 12'h045, 1'b0, 1'b0);
      ticks(3);
      expect_out("pause_hold", 12'h045, 1'b0, 1'b0);
      press_start();
      expect_out("resume", 12'h045, 1'b1, 1'b0);
      ticks(1);
      expect_out("resume_dec", 12'h044, 1'b1, 1'b0);
      press_clear(); press_clear();
      expect_out("clear_idle", 12'h000, 1'b0, 1'b0);
`else
      key(4'd5);
      press_start();
      expect_out("pre_start", 12'h005, 1'b1, 1'b0);
      idle(CPS - 1);
      expect_out("pre_first", 12'h005, 1'b1, 1'b0);
      idle(1);
      expect_out("first_dec", 12'h004, 1'b1, 1'b0);
      press_clear(); press_clear();
`endif

      key(4'd3); key(4'd1); key(4'd2);
      press_start();
      reset = 1'b1;
      step();
      expect_out("reset_run", 12'h000, 1'b0, 1'b0);

      for (int i = 0; i < 4000; i++) begin
         reset      = ($urandom_range(0, 199) == 0);
         key_valid  = ($urandom_range(0, 9) < 3);
         key_digit  = 4'($urandom_range(0, 15));
         start      = ($urandom_range(0, 9) == 0);
         stop_clear = ($urandom_range(0, 29) == 0);
         sec_tick   = ($urandom_range(0, 9) < 4);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
